// File: rtl/logic_issue_arbiter_pkg.sv
// logic_issue_arbiter_pkg: logic control codes, result-buffer depth and default operand width
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
package logic_issue_arbiter_pkg;
   localparam int MSB_CTRL = 2;
   localparam logic [2:0] CTRL_AND  = 3'b000;
   localparam logic [2:0] CTRL_OR   = 3'b001;
   localparam logic [2:0] CTRL_XOR  = 3'b010;
   localparam logic [2:0] CTRL_ANDI = 3'b100;
   localparam logic [2:0] CTRL_ORI  = 3'b101;
   localparam logic [2:0] CTRL_XORI = 3'b110;
   localparam int LU_ARB_DEPTH = 2;
   // result entries are packed MSB-first as {data, tag, src}
   function automatic int lu_entry_width(input int dw, input int tw);
      return dw + tw + 1;
   endfunction
endpackage

// File: rtl/logic_issue_arbiter_fifo.sv
// lu_arb_fifo: 2-entry synchronous result FIFO with occupancy count
module lu_arb_fifo
   import logic_issue_arbiter_pkg::*;
#(
   parameter int W = 38
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] data_o,
   output logic         valid_o,
   output logic [1:0]   count_o
);
   logic [W-1:0] mem_q [LU_ARB_DEPTH];
   logic         wr_q, rd_q;
   logic [1:0]   count_q, count_d;
   assign count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
   assign data_o  = mem_q[rd_q];
   assign valid_o = count_q != 2'd0;
   assign count_o = count_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) mem_q[wr_q] <= data_i;
         wr_q    <= wr_q ^ push_i;
         rd_q    <= rd_q ^ pop_i;
         count_q <= count_d;
      end
   end
   // upstream credit must never let a push land on a full buffer without a pop
   assert property (@(posedge clk) disable iff (!rst_n) !(push_i && !pop_i && count_q == 2'd2));
endmodule

// File: rtl/logic_issue_arbiter.sv
// logic_issue_arbiter: round-robin issue of two requesters onto one logical_unit; LU_ARB_PERF_CNT_EN adds grant/stall counters
module logic_issue_arbiter
   import logic_issue_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int TAG_WIDTH  = 5,
   parameter int OUT_DEPTH  = LU_ARB_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [2:0]            req0_type,
   input  logic [DATA_WIDTH-1:0] req0_src1,
   input  logic [DATA_WIDTH-1:0] req0_src2,
   input  logic [20:0]           req0_imm,
   input  logic [TAG_WIDTH-1:0]  req0_tag,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [2:0]            req1_type,
   input  logic [DATA_WIDTH-1:0] req1_src1,
   input  logic [DATA_WIDTH-1:0] req1_src2,
   input  logic [20:0]           req1_imm,
   input  logic [TAG_WIDTH-1:0]  req1_tag,
   output logic                  lu_uop_valid,
   output logic [2:0]            lu_logic_type,
   output logic [DATA_WIDTH-1:0] lu_src1,
   output logic [DATA_WIDTH-1:0] lu_src2,
   output logic [20:0]           lu_imm,
   input  logic [DATA_WIDTH-1:0] lu_result,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [DATA_WIDTH-1:0] res_data,
   output logic [TAG_WIDTH-1:0]  res_tag,
   output logic                  res_src,
   output logic                  busy
`ifdef LU_ARB_PERF_CNT_EN
   ,
   output logic [31:0]           perf_grant0,
   output logic [31:0]           perf_grant1,
   output logic [31:0]           perf_stall
`endif
);
   localparam int EW = lu_entry_width(DATA_WIDTH, TAG_WIDTH);
   logic                  rr_q, rr_d, e1_valid_q, e1_src_q, pop, credit_ok, gnt, gnt_src;
   logic [2:0]            e1_type_q;
   logic [TAG_WIDTH-1:0]  e1_tag_q;
   logic [DATA_WIDTH-1:0] src1_q, src2_q;
   logic [20:0]           imm_q;
   logic [1:0]            count;
   logic [EW-1:0]         head;
   assign pop       = res_valid & res_ready;
   // counts the op in E1 as already occupying a slot, so a grant never overruns the buffer
   assign credit_ok = ({1'b0, count} + {2'b0, e1_valid_q} - {2'b0, pop}) < 3'(OUT_DEPTH);
   always_comb begin
      gnt     = reset & (req0_valid | req1_valid) & credit_ok;
      gnt_src = (req0_valid & req1_valid) ? rr_q : req1_valid;
      rr_d    = gnt ? ~gnt_src : rr_q;
   end
   assign req0_ready    = gnt & ~gnt_src;
   assign req1_ready    = gnt & gnt_src;
   assign lu_src1       = !gnt ? src1_q : gnt_src ? req1_src1 : req0_src1;
   assign lu_src2       = !gnt ? src2_q : gnt_src ? req1_src2 : req0_src2;
   assign lu_imm        = !gnt ? imm_q  : gnt_src ? req1_imm  : req0_imm;
   assign lu_uop_valid  = e1_valid_q;
   assign lu_logic_type = e1_type_q;
   assign busy          = e1_valid_q | res_valid;
   assign {res_data, res_tag, res_src} = head;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_q       <= 1'b0;
         e1_valid_q <= 1'b0;
         e1_src_q   <= 1'b0;
         e1_type_q  <= '0;
         e1_tag_q   <= '0;
         src1_q     <= '0;
         src2_q     <= '0;
         imm_q      <= '0;
      end else begin
         rr_q       <= rr_d;
         e1_valid_q <= gnt;
         if (gnt) begin
            e1_src_q  <= gnt_src;
            e1_type_q <= gnt_src ? req1_type : req0_type;
            e1_tag_q  <= gnt_src ? req1_tag : req0_tag;
            src1_q    <= lu_src1;
            src2_q    <= lu_src2;
            imm_q     <= lu_imm;
         end
      end
   end
   lu_arb_fifo #(.W(EW)) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (e1_valid_q),
      .data_i  ({lu_result, e1_tag_q, e1_src_q}),
      .pop_i   (pop),
      .data_o  (head),
      .valid_o (res_valid),
      .count_o (count)
   );
`ifdef LU_ARB_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_grant0 <= '0;
         perf_grant1 <= '0;
         perf_stall  <= '0;
      end else begin
         perf_grant0 <= perf_grant0 + {31'b0, req0_ready};
         perf_grant1 <= perf_grant1 + {31'b0, req1_ready};
         perf_stall  <= perf_stall + {31'b0, (req0_valid | req1_valid) & ~credit_ok};
      end
   end
`endif
endmodule

// File: tb/tb_logic_issue_arbiter.sv
// tb_logic_issue_arbiter: directed checks of arbitration, latency, credit and reset with a behavioural logical_unit
module tb_logic_issue_arbiter;
   import logic_issue_arbiter_pkg::*;
   localparam logic [2:0] UNDEF_T = 3'b011;
   logic        clk = 1'b0, reset = 1'b0;
   logic        req0_valid = 1'b0, req0_ready, req1_valid = 1'b0, req1_ready;
   logic [2:0]  req0_type = '0, req1_type = '0;
   logic [31:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
   logic [20:0] req0_imm = '0, req1_imm = '0;
   logic [4:0]  req0_tag = '0, req1_tag = '0;
   logic        lu_uop_valid, res_valid, res_ready = 1'b1, res_src, busy;
   logic [2:0]  lu_logic_type;
   logic [31:0] lu_src1, lu_src2, lu_result, res_data;
   logic [20:0] lu_imm;
   logic [4:0]  res_tag;
   logic [31:0] u_s1 = '0, u_s2 = '0;
   logic [20:0] u_imm = '0;
   int          passed = 0, total = 0;
`ifdef LU_ARB_PERF_CNT_EN
   logic [31:0] perf_grant0, perf_grant1, perf_stall;
`endif
   always #5 clk = ~clk;
   logic_issue_arbiter dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_type(req0_type),
      .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_imm(req0_imm), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_type(req1_type),
      .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_imm(req1_imm), .req1_tag(req1_tag),
      .lu_uop_valid(lu_uop_valid), .lu_logic_type(lu_logic_type), .lu_src1(lu_src1),
      .lu_src2(lu_src2), .lu_imm(lu_imm), .lu_result(lu_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
      .res_src(res_src), .busy(busy)
`ifdef LU_ARB_PERF_CNT_EN
      , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
   );
   // behavioural logical_unit: operands registered, result combinational from the registered operands
   function automatic logic [31:0] lu_model(input logic v, input logic [2:0] t, input logic [31:0] a,
                                            input logic [31:0] b, input logic [20:0] imm);
      logic [31:0] i;
      i = {11'b0, imm};
      if (!v) return '0;
      case (t)
         CTRL_AND:  return a & b;
         CTRL_OR:   return a | b;
         CTRL_XOR:  return a ^ b;
         CTRL_ANDI: return a & i;
         CTRL_ORI:  return a | i;
         CTRL_XORI: return a ^ i;
         default:   return '0;
      endcase
   endfunction
   always @(posedge clk) begin
      u_s1  <= lu_src1;
      u_s2  <= lu_src2;
      u_imm <= lu_imm;
   end
   assign lu_result = lu_model(lu_uop_valid, lu_logic_type, u_s1, u_s2, u_imm);
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic do_reset();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready  = 1'b1;
      reset      = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask
   task automatic test_reset();
      @(negedge clk);
      req0_valid = 1'b1;
      #1;
      total++; if (req0_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", req0_ready); else passed++;
      total++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid got %b want 0", res_valid); else passed++;
      total++; if (lu_uop_valid !== 1'b0) $display("FAIL rst_uop_valid got %b want 0", lu_uop_valid); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
      total++; if (res_data !== 32'h0) $display("FAIL rst_res_data got %h want 0", res_data); else passed++;
      req0_valid = 1'b0;
      tick();
      reset = 1'b1;
   endtask
   task automatic test_and();
      req0_valid = 1'b1; req0_type = CTRL_AND; req0_src1 = 32'hF0F0_00FF; req0_src2 = 32'h0FF0_0F0F; req0_tag = 5'd3;
      #1;
      total++; if (req0_ready !== 1'b1) $display("FAIL and_ready got %b want 1", req0_ready); else passed++;
      total++; if (lu_src1 !== 32'hF0F0_00FF) $display("FAIL and_lu_src1 got %h want f0f000ff", lu_src1); else passed++;
      tick();
      req0_valid = 1'b0;
      #1;
      total++; if (lu_uop_valid !== 1'b1 || res_valid !== 1'b0) $display("FAIL and_e1 got uop=%b res_valid=%b want 1/0", lu_uop_valid, res_valid); else passed++;
      tick();
      #1;
      total++; if ({res_valid, res_data, res_tag, res_src} !== {1'b1, 32'h00F0_000F, 5'd3, 1'b0})
         $display("FAIL and_result got v=%b d=%h t=%0d s=%b want 1 00f0000f 3 0", res_valid, res_data, res_tag, res_src); else passed++;
      tick();
      #1;
      total++; if (busy !== 1'b0) $display("FAIL and_idle_busy got %b want 0", busy); else passed++;
   endtask
   task automatic test_fairness();
      logic [5:0] gnts, srcs;
      int one_hot, nres;
      logic [31:0] d3;
      gnts = '0; srcs = '0; one_hot = 0; nres = 0; d3 = '0;
      do_reset();
      req0_type = CTRL_AND; req0_src1 = 32'hAAAA_0000; req0_src2 = 32'hFFFF_FFFF; req0_tag = 5'd1;
      req1_type = CTRL_OR;  req1_src1 = 32'h0000_5555; req1_src2 = 32'h0000_8000; req1_tag = 5'd2;
      for (int c = 0; c < 8; c++) begin
         req0_valid = c < 6;
         req1_valid = c < 6;
         #1;
         if (c < 6) begin
            gnts[c] = req1_ready;
            if ((req0_ready ^ req1_ready) === 1'b1) one_hot++;
         end
         if (c >= 2) begin
            srcs[c-2] = res_src;
            if (res_valid === 1'b1) nres++;
         end
         if (c == 3) d3 = res_data;
         tick();
      end
      #1;
      total++; if (gnts !== 6'b101010) $display("FAIL fair_order got %b want 101010", gnts); else passed++;
      total++; if (one_hot !== 6) $display("FAIL fair_one_ready got %0d want 6", one_hot); else passed++;
      total++; if (nres !== 6) $display("FAIL fair_res_count got %0d want 6", nres); else passed++;
      total++; if (srcs !== 6'b101010) $display("FAIL fair_res_src got %b want 101010", srcs); else passed++;
      total++; if (d3 !== 32'h0000_D555) $display("FAIL fair_or_data got %h want 0000d555", d3); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL fair_drain_busy got %b want 0", busy); else passed++;
   endtask
   task automatic test_backpressure();
      int ng;
      ng = 0;
      do_reset();
      res_ready = 1'b0;
      req0_type = CTRL_XOR; req0_src1 = 32'h1234_5678; req0_src2 = 32'hFFFF_0000;
      for (int c = 0; c < 6; c++) begin
         req0_valid = 1'b1;
         req0_tag = 5'(16 + c);
         #1;
         if (req0_ready === 1'b1) ng++;
         if (c == 5) begin
            total++; if (req0_ready !== 1'b0) $display("FAIL bp_ready_low got %b want 0", req0_ready); else passed++;
            total++; if (res_valid !== 1'b1 || res_tag !== 5'h10) $display("FAIL bp_head_hold got v=%b t=%h want 1 10", res_valid, res_tag); else passed++;
            total++; if (res_data !== 32'hEDCB_5678) $display("FAIL bp_head_data got %h want edcb5678", res_data); else passed++;
         end
         tick();
      end
      total++; if (ng !== 2) $display("FAIL bp_grants got %0d want 2", ng); else passed++;
      res_ready = 1'b1;
      req0_tag = 5'h16;
      #1;
      total++; if (req0_ready !== 1'b1 || res_tag !== 5'h10) $display("FAIL bp_resume got rdy=%b t=%h want 1 10", req0_ready, res_tag); else passed++;
      tick();
      req0_valid = 1'b0;
      #1;
      total++; if (res_valid !== 1'b1 || res_tag !== 5'h11) $display("FAIL bp_pop2 got v=%b t=%h want 1 11", res_valid, res_tag); else passed++;
      tick();
      #1;
      total++; if (res_valid !== 1'b1 || res_tag !== 5'h16) $display("FAIL bp_pop3 got v=%b t=%h want 1 16", res_valid, res_tag); else passed++;
      tick();
   endtask
   task automatic test_ori_undef();
      req1_valid = 1'b1; req1_type = CTRL_ORI; req1_src1 = 32'h1000_0000; req1_imm = 21'h1F_FFFF; req1_tag = 5'd7;
      #1;
      total++; if (req1_ready !== 1'b1 || lu_imm !== 21'h1F_FFFF) $display("FAIL ori_issue got rdy=%b imm=%h want 1 1fffff", req1_ready, lu_imm); else passed++;
      tick();
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_type = UNDEF_T; req0_src1 = 32'hFFFF_FFFF; req0_src2 = 32'hFFFF_FFFF; req0_tag = 5'd9;
      #1;
      total++; if (req0_ready !== 1'b1) $display("FAIL undef_accept got %b want 1", req0_ready); else passed++;
      tick();
      req0_valid = 1'b0;
      #1;
      total++; if ({res_valid, res_data, res_tag, res_src} !== {1'b1, 32'h101F_FFFF, 5'd7, 1'b1})
         $display("FAIL ori_result got v=%b d=%h t=%0d s=%b want 1 101fffff 7 1", res_valid, res_data, res_tag, res_src); else passed++;
      tick();
      #1;
      total++; if ({res_valid, res_data, res_tag, res_src} !== {1'b1, 32'h0, 5'd9, 1'b0})
         $display("FAIL undef_result got v=%b d=%h t=%0d s=%b want 1 0 9 0", res_valid, res_data, res_tag, res_src); else passed++;
      tick();
   endtask
   task automatic test_reset_midop();
      req0_valid = 1'b1; req0_type = CTRL_AND; req0_src1 = 32'hFFFF_FFFF; req0_src2 = 32'h1111_1111; req0_tag = 5'd5;
      tick();
      req0_valid = 1'b0;
      reset = 1'b0;
      #1;
      total++; if (lu_uop_valid !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_e1 got uop=%b busy=%b want 0 0", lu_uop_valid, busy); else passed++;
      tick();
      #1;
      total++; if (res_valid !== 1'b0) $display("FAIL midrst_res got %b want 0", res_valid); else passed++;
      tick();
      reset = 1'b1;
      req0_valid = 1'b1; req0_src1 = 32'hFFFF_0000; req0_src2 = 32'h0F0F_0F0F; req0_tag = 5'd4;
      #1;
      total++; if (req0_ready !== 1'b1 || res_valid !== 1'b0) $display("FAIL midrst_new got rdy=%b v=%b want 1 0", req0_ready, res_valid); else passed++;
      tick();
      req0_valid = 1'b0;
      #1;
      total++; if (res_valid !== 1'b0) $display("FAIL midrst_lat1 got %b want 0", res_valid); else passed++;
      tick();
      #1;
      total++; if ({res_valid, res_data, res_tag} !== {1'b1, 32'h0F0F_0000, 5'd4})
         $display("FAIL midrst_lat2 got v=%b d=%h t=%0d want 1 0f0f0000 4", res_valid, res_data, res_tag); else passed++;
      tick();
   endtask
`ifdef LU_ARB_PERF_CNT_EN
   task automatic test_perf();
      do_reset();
      res_ready = 1'b0;
      req0_valid = 1'b1;
      for (int c = 0; c < 7; c++) tick();
      req0_valid = 1'b0;
      res_ready = 1'b1;
      for (int c = 0; c < 3; c++) tick();
      req0_valid = 1'b1;
      tick();
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1;
      for (int c = 0; c < 3; c++) tick();
      req1_valid = 1'b0;
      #1;
      total++; if (perf_grant0 !== 32'd4) $display("FAIL perf_grant0 got %0d want 4", perf_grant0); else passed++;
      total++; if (perf_grant1 !== 32'd3) $display("FAIL perf_grant1 got %0d want 3", perf_grant1); else passed++;
      total++; if (perf_stall !== 32'd5) $display("FAIL perf_stall got %0d want 5", perf_stall); else passed++;
      tick();
   endtask
`endif
   initial begin
      test_reset();
      test_and();
      test_fairness();
      test_backpressure();
      test_ori_undef();
      test_reset_midop();
`ifdef LU_ARB_PERF_CNT_EN
      test_perf();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
